// File: rtl/program_counter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : program_counter_pkg
//  Description : Shared encodings for the program-counter stage.
//                - PC_BASEX_*   : base-address select codes
//                - PC_OFFSETX_* : offset select codes
//                - int_state_t  : interrupt arbitration states
//                - pc_align()   : clears bit 0 so fetch addresses stay
//                                 word aligned
//  Revision    : 1.0 - initial release
// ============================================================================
package program_counter_pkg;

    localparam int C_PC_W = 16;

    // Base select codes. The unused fourth code behaves like PC_BASEX_PC_A.
    localparam logic [1:0] PC_BASEX_PC_A = 2'b00;
    localparam logic [1:0] PC_BASEX_0    = 2'b01;
    localparam logic [1:0] PC_BASEX_ARGB = 2'b10;

    // Offset select codes. The unused fourth code behaves like PC_OFFSETX_0.
    localparam logic [1:0] PC_OFFSETX_0   = 2'b00;
    localparam logic [1:0] PC_OFFSETX_2   = 2'b01;
    localparam logic [1:0] PC_OFFSETX_DIN = 2'b10;

    // Single-level interrupt arbitration states.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_PENDING = 2'b01,
        ST_ACTIVE  = 2'b10
    } int_state_t;

    // Force an address onto a word boundary.
    function automatic logic [C_PC_W-1:0] pc_align(input logic [C_PC_W-1:0] addr);
        return {addr[C_PC_W-1:1], 1'b0};
    endfunction

endpackage : program_counter_pkg
`default_nettype wire

// File: rtl/pc_adder.sv
`default_nettype none
// ============================================================================
//  Module      : pc_adder
//  Description : Next-address former. Selects a base and an offset, adds
//                them modulo 2^16 and clears bit 0. Purely combinational.
//  Ports       : i_base_sel  - base select code (PC_BASEX_*)
//                i_off_sel   - offset select code (PC_OFFSETX_*)
//                i_pc_a      - address of the executing instruction
//                i_argb      - register-file B operand
//                i_din       - immediate word from the data bus
//                o_next      - aligned base + offset
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_adder
    import program_counter_pkg::*;
(
    input  logic [1:0]        i_base_sel,
    input  logic [1:0]        i_off_sel,
    input  logic [C_PC_W-1:0] i_pc_a,
    input  logic [C_PC_W-1:0] i_argb,
    input  logic [C_PC_W-1:0] i_din,
    output logic [C_PC_W-1:0] o_next
);

    logic [C_PC_W-1:0] w_base;
    logic [C_PC_W-1:0] w_offset;
    logic [C_PC_W-1:0] w_sum;

    always_comb begin
        w_base = i_pc_a;
        case (i_base_sel)
            PC_BASEX_0:    w_base = '0;
            PC_BASEX_ARGB: w_base = i_argb;
            default:       w_base = i_pc_a;
        endcase
    end

    always_comb begin
        w_offset = '0;
        case (i_off_sel)
            PC_OFFSETX_2:   w_offset = 16'd2;
            PC_OFFSETX_DIN: w_offset = i_din;
            default:        w_offset = '0;
        endcase
    end

    // Carry out of bit 15 is discarded: addresses wrap silently.
    assign w_sum  = w_base + w_offset;
    assign o_next = pc_align(w_sum);

endmodule : pc_adder
`default_nettype wire

// File: rtl/program_counter.sv
`default_nettype none
// ============================================================================
//  Module      : program_counter
//  Description : PC register, executing-instruction address (PC_A) and a
//                single-level interrupt arbiter (vector entry, return
//                address save, return).
//  Ports       : CLK        - clock, rising edge
//                RESET_N    - synchronous active-low reset
//                PC_BASEX   - base select for the next address
//                PC_OFFSETX - offset select for the next address
//                DIN        - immediate word from the data bus
//                ARGB       - register-file B operand
//                PC_LD      - commit PC_NEXT to PC
//                PC_A_LD    - capture PC into PC_A
//                INT_REQ    - level interrupt request
//                RETI       - return-from-interrupt strobe
//                PC         - current fetch address
//                PC_A       - address of the executing instruction
//                PC_NEXT    - combinational base + offset
//                INT_RA     - saved interrupt return address
//                INT_ACK    - one-cycle pulse after vector entry
//                INT_ACTIVE - high while the handler runs
//  Revision    : 1.0 - initial release
// ============================================================================
module program_counter
    import program_counter_pkg::*;
#(
    parameter logic [15:0] RESET_VECTOR = 16'h0000,
    parameter logic [15:0] INT_VECTOR   = 16'h0004
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic [1:0]  PC_BASEX,
    input  logic [1:0]  PC_OFFSETX,
    input  logic [15:0] DIN,
    input  logic [15:0] ARGB,
    input  logic        PC_LD,
    input  logic        PC_A_LD,
    input  logic        INT_REQ,
    input  logic        RETI,
    output logic [15:0] PC,
    output logic [15:0] PC_A,
    output logic [15:0] PC_NEXT,
    output logic [15:0] INT_RA,
    output logic        INT_ACK,
    output logic        INT_ACTIVE
);

    int_state_t  r_state;
    int_state_t  w_state_next;
    logic        w_int_entry;
    logic        w_reti_take;
    logic [15:0] w_next;
    logic [15:0] r_pc;
    logic [15:0] r_pc_a;
    logic [15:0] r_int_ra;
    logic        r_int_ack;

    pc_adder u_pc_adder (
        .i_base_sel (PC_BASEX),
        .i_off_sel  (PC_OFFSETX),
        .i_pc_a     (r_pc_a),
        .i_argb     (ARGB),
        .i_din      (DIN),
        .o_next     (w_next)
    );

    // ------------------------------------------------------------------
    // Interrupt arbiter: state register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Interrupt arbiter: next state and qualified strobes.
    // A request is only sampled in IDLE, so a RETI cycle that also sees
    // INT_REQ lands in IDLE and the request is picked up a cycle later.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_int_entry  = 1'b0;
        w_reti_take  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (INT_REQ) begin
                    w_state_next = ST_PENDING;
                end
            end
            ST_PENDING: begin
                // Once pending, the entry is committed even if the
                // request is withdrawn; it hijacks the next PC load.
                if (PC_LD) begin
                    w_int_entry  = 1'b1;
                    w_state_next = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (RETI) begin
                    w_reti_take  = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // PC register: return beats entry beats a normal load.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            r_pc <= RESET_VECTOR;
        end else if (w_reti_take) begin
            r_pc <= r_int_ra;
        end else if (w_int_entry) begin
            r_pc <= INT_VECTOR;
        end else if (PC_LD) begin
            r_pc <= w_next;
        end
    end

    // PC_A samples the pre-edge PC, so a simultaneous load is not seen.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            r_pc_a <= RESET_VECTOR;
        end else if (PC_A_LD) begin
            r_pc_a <= r_pc;
        end
    end

    // The return address is the load target the interrupt displaced.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            r_int_ra  <= '0;
            r_int_ack <= 1'b0;
        end else begin
            r_int_ack <= w_int_entry;
            if (w_int_entry) begin
                r_int_ra <= w_next;
            end
        end
    end

    assign PC         = r_pc;
    assign PC_A       = r_pc_a;
    assign PC_NEXT    = w_next;
    assign INT_RA     = r_int_ra;
    assign INT_ACK    = r_int_ack;
    assign INT_ACTIVE = (r_state == ST_ACTIVE);

endmodule : program_counter
`default_nettype wire
